regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-port-pair integer register file used by the core top level.
- Generalised in register width, register count, read-port count and write-port count.
- Adds write-first bypass and a per-register busy-bit scoreboard, so a pipelined core can issue, detect RAW/WAW hazards and retire results from multiple writeback sources.
- Sits between decode/issue and the execute/load writeback paths.

Parameters:
XLEN, 64, register data width in bits
NREG, 32, number of architectural registers; register 0 is hardwired to zero
NRD, 2, number of read ports
NWR, 2, number of writeback ports; a higher index has priority on address conflict
AW, $clog2(NREG), register address width (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
r_ena  in  NRD  per-port read enable
r_addr  in  NRD*AW  read addresses, port i at bits [i*AW +: AW]
r_data  out  NRD*XLEN  read data, port i at bits [i*XLEN +: XLEN]
r_busy  out  NRD  per-port RAW hazard flag
iss_valid  in  1  issue request from decode
iss_rd_ena  in  1  issuing instruction writes a destination register
iss_rd_addr  in  AW  destination register of the issuing instruction
iss_ready  out  1  issue accepted this cycle when iss_valid is high
wb_ena  in  NWR  per-port writeback valid
wb_addr  in  NWR*AW  writeback addresses
wb_data  in  NWR*XLEN  writeback data
busy_cnt  out  $clog2(NREG)+1  number of registers currently marked busy

Behaviour:
- Reset (rst=1 at an edge): all registers cleared to 0; all busy bits cleared; busy_cnt=0. While rst is high, iss_ready=0 and r_busy=0. Reset mid-operation discards all pending busy marks.
- Read path (combinational, 0-cycle latency):
  - r_ena[i]=0 forces r_data[i]=0 and r_busy[i]=0.
  - r_addr[i]=0 forces r_data[i]=0 and r_busy[i]=0.
  - Otherwise, if any wb_ena[j] matches r_addr[i] in this cycle, r_data[i] takes the highest-index matching wb_data[j] (write-first bypass). If no port matches, r_data[i] is the stored value.
- RAW flag: r_busy[i] = busy[r_addr[i]] AND no wb_ena[j] with wb_addr[j]==r_addr[i] this cycle.
- Write path: at each edge, for every wb_ena[j] with a non-zero address, the register is written. If multiple ports target the same address, the highest index wins. Writes to register 0 are ignored.
- Scoreboard:
  - busy[k] is set at the edge when an issue fires with iss_rd_ena=1 and iss_rd_addr=k≠0.
  - busy[k] is cleared at the edge when any wb_ena[j] targets k.
  - If an issue and a writeback hit the same k in the same cycle, set wins and busy stays 1, because the issuer is the newer writer.
  - busy[0] is permanently 0.
- iss_ready = NOT rst AND no r_busy[i] asserted AND NOT (iss_rd_ena AND iss_rd_addr≠0 AND busy[iss_rd_addr] AND no same-cycle writeback to iss_rd_addr).
  - This covers both RAW and WAW stalls. The read ports are the issuing instruction's sources.
- Issue fires when iss_valid AND iss_ready. iss_ready is asserted independently of iss_valid (no combinational dependency on iss_valid).
- busy_cnt is registered and equals the popcount of busy after each edge. It changes by at most +1 and −NWR per cycle.
- A writeback to a non-busy register is legal (e.g. a CSR-less direct write). It updates data, and busy stays 0.

Decomposition:
- Shared package (sys_defs):
  - XLEN default, NREG default
  - a reg_addr_t typedef sized AW
  - a WB_PORT_ALU=0 / WB_PORT_LSU=1 index constant pair, so the core top level binds writeback sources consistently
- One natural sub-module: regfile_bypass_mux. It is a combinational per-read-port priority match across the NWR writeback ports, returning the hit flag and the data. It is instantiated NRD times and reused for the RAW and WAW checks.

Test Plan:
- Reset then read: rst=1 for 2 cycles, then r_ena=2'b11, r_addr={5,3} -> r_data both 0, r_busy=0, iss_ready=1, busy_cnt=0.
- Write/read/bypass: wb_ena[0]=1, addr 3, data 64'hDEAD_BEEF, with r_addr[0]=3 in the same cycle -> r_data[0]=DEAD_BEEF in that cycle and on the next cycle via the stored value. Writing addr 0 with data 5 -> reads of x0 return 0.
- RAW stall: issue iss_rd_addr=7 -> busy_cnt=1 next cycle. Then read r_addr[1]=7 -> r_busy[1]=1 and iss_ready=0. Assert wb_ena[1] with addr 7, data 42 -> same cycle r_busy[1]=0, r_data[1]=42, iss_ready=1; next cycle busy_cnt=0.
- WAW stall: busy[9]=1, issue with iss_rd_addr=9 and no reads -> iss_ready=0. With a same-cycle wb to 9 -> iss_ready=1, and after the edge busy[9]=1, busy_cnt unchanged at 1.
- Write-port conflict: wb_ena=2'b11, both addr 4, data0=1, data1=2 -> bypass and stored value are both 2.
- Reset mid-operation: busy set on x2, x5, x6 (busy_cnt=3), then rst=1 for one cycle -> busy_cnt=0, all registers 0, iss_ready=1 once rst drops.

Source files
------------

// File: rtl/sys_defs.sv
// Shared core definitions: register file geometry and writeback port binding.
package sys_defs;

    localparam int XLEN_DEF = 64;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

    localparam int WB_PORT_ALU = 0;
    localparam int WB_PORT_LSU = 1;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Priority match of one register address against all writeback ports.
module regfile_bypass_mux #(
    parameter int XLEN = 64,
    parameter int NWR  = 2,
    parameter int AW   = 5
) (
    input  logic [AW-1:0]       addr,
    input  logic [NWR-1:0]      wb_ena,
    input  logic [NWR*AW-1:0]   wb_addr,
    input  logic [NWR*XLEN-1:0] wb_data,
    output logic                hit,
    output logic [XLEN-1:0]     data
);

    // Ascending scan: the highest-index matching port is the last to assign.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wb_ena[j] && wb_addr[j*AW +: AW] == addr) begin
                hit  = 1'b1;
                data = wb_data[j*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with write-first bypass and a
// busy-bit scoreboard for RAW/WAW issue stalls.
module regfile_scoreboard
    import sys_defs::*;
#(
    parameter int  XLEN = XLEN_DEF,
    parameter int  NREG = NREG_DEF,
    parameter int  NRD  = 2,
    parameter int  NWR  = 2,
    localparam int AW   = $clog2(NREG),
    localparam int CW   = $clog2(NREG) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      r_ena,
    input  logic [NRD*AW-1:0]   r_addr,
    output logic [NRD*XLEN-1:0] r_data,
    output logic [NRD-1:0]      r_busy,
    input  logic                iss_valid,
    input  logic                iss_rd_ena,
    input  logic [AW-1:0]       iss_rd_addr,
    output logic                iss_ready,
    input  logic [NWR-1:0]      wb_ena,
    input  logic [NWR*AW-1:0]   wb_addr,
    input  logic [NWR*XLEN-1:0] wb_data,
    output logic [CW-1:0]       busy_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            iss_hit;
    logic [XLEN-1:0] iss_byp;
    logic            waw;
    logic            fire;

    function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int k = 0; k < NREG; k++) begin
            c = c + {{(CW-1){1'b0}}, v[k]};
        end
        return c;
    endfunction

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   a;
        logic            hit;
        logic [XLEN-1:0] byp;
        logic            live;

        assign a    = r_addr[i*AW +: AW];
        assign live = r_ena[i] && (a != '0);

        regfile_bypass_mux #(
            .XLEN (XLEN),
            .NWR  (NWR),
            .AW   (AW)
        ) u_byp (
            .addr    (a),
            .wb_ena  (wb_ena),
            .wb_addr (wb_addr),
            .wb_data (wb_data),
            .hit     (hit),
            .data    (byp)
        );

        assign r_data[i*XLEN +: XLEN] = !live ? '0 : (hit ? byp : regs[a]);
        assign r_busy[i] = !rst && live && busy[a] && !hit;
    end

    // Same matcher on the destination address detects a pending WAW.
    regfile_bypass_mux #(
        .XLEN (XLEN),
        .NWR  (NWR),
        .AW   (AW)
    ) u_iss (
        .addr    (iss_rd_addr),
        .wb_ena  (wb_ena),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .hit     (iss_hit),
        .data    (iss_byp)
    );

    assign waw = iss_rd_ena && (iss_rd_addr != '0)
               && busy[iss_rd_addr] && !iss_hit;

    assign iss_ready = !rst && !(|r_busy) && !waw;
    assign fire      = iss_valid && iss_ready;

    // Clears first, then the set: a same-cycle issue is the newer writer.
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NWR; j++) begin
            if (wb_ena[j]) begin
                busy_nxt[wb_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (fire && iss_rd_ena) begin
            busy_nxt[iss_rd_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= popcount(busy_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wb_ena[j] && wb_addr[j*AW +: AW] != '0) begin
                    regs[wb_addr[j*AW +: AW]] <= wb_data[j*XLEN +: XLEN];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized and directed check of regfile_scoreboard against an
// array-based reference model of the register file and busy set.
module tb_regfile_scoreboard;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   r_ena;
    logic [9:0]   r_addr;
    logic [127:0] r_data;
    logic [1:0]   r_busy;
    logic         iss_valid;
    logic         iss_rd_ena;
    logic [4:0]   iss_rd_addr;
    logic         iss_ready;
    logic [1:0]   wb_ena;
    logic [9:0]   wb_addr;
    logic [127:0] wb_data;
    logic [5:0]   busy_cnt;

    regfile_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .r_ena       (r_ena),
        .r_addr      (r_addr),
        .r_data      (r_data),
        .r_busy      (r_busy),
        .iss_valid   (iss_valid),
        .iss_rd_ena  (iss_rd_ena),
        .iss_rd_addr (iss_rd_addr),
        .iss_ready   (iss_ready),
        .wb_ena      (wb_ena),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .busy_cnt    (busy_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_reg [32];
    bit          m_busy [32];
    bit          exp_rdy;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int model_cnt();
        int n = 0;
        for (int k = 0; k < 32; k++) n += int'(m_busy[k]);
        return n;
    endfunction

    // Does any writeback this cycle target address a? Returns last match.
    function automatic bit wb_match(input logic [4:0] a,
                                    output logic [63:0] v);
        bit h = 0;
        v = '0;
        for (int j = 0; j < 2; j++) begin
            if (wb_ena[j] && wb_addr[j*5 +: 5] == a) begin
                h = 1;
                v = wb_data[j*64 +: 64];
            end
        end
        return h;
    endfunction

    task automatic apply(input bit rs, input logic [1:0] re,
                         input logic [4:0] a0, input logic [4:0] a1,
                         input bit iv, input bit ie, input logic [4:0] ia,
                         input logic [1:0] we,
                         input logic [4:0] wa0, input logic [63:0] wd0,
                         input logic [4:0] wa1, input logic [63:0] wd1);
        logic [63:0] ed [2];
        logic [1:0]  eb;
        logic [63:0] v;
        logic [4:0]  a;
        bit          h;
        rst         = rs;
        r_ena       = re;
        r_addr      = {a1, a0};
        iss_valid   = iv;
        iss_rd_ena  = ie;
        iss_rd_addr = ia;
        wb_ena      = we;
        wb_addr     = {wa1, wa0};
        wb_data     = {wd1, wd0};
        #1;
        for (int i = 0; i < 2; i++) begin
            a = r_addr[i*5 +: 5];
            ed[i] = '0;
            eb[i] = 1'b0;
            if (re[i] && a != 0) begin
                h = wb_match(a, v);
                ed[i] = h ? v : m_reg[a];
                eb[i] = !rs && m_busy[a] && !h;
            end
        end
        exp_rdy = !rs && eb == 2'b00
                  && !(ie && ia != 0 && m_busy[ia] && !wb_match(ia, v));
        chk("r_data0", r_data[63:0], ed[0]);
        chk("r_data1", r_data[127:64], ed[1]);
        chk("r_busy", {62'd0, r_busy}, {62'd0, eb});
        chk("iss_ready", {63'd0, iss_ready}, {63'd0, exp_rdy});
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 32; k++) begin
                m_reg[k]  = '0;
                m_busy[k] = 0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (wb_ena[j] && wb_addr[j*5 +: 5] != 0) begin
                    m_reg[wb_addr[j*5 +: 5]]  = wb_data[j*64 +: 64];
                    m_busy[wb_addr[j*5 +: 5]] = 0;
                end
            end
            if (iss_valid && exp_rdy && iss_rd_ena && iss_rd_addr != 0)
                m_busy[iss_rd_addr] = 1;
        end
        #1;
        chk("busy_cnt", {58'd0, busy_cnt}, 64'(model_cnt()));
        @(negedge clk);
    endtask

    task automatic idle();
        apply(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin
            m_reg[k]  = '0;
            m_busy[k] = 0;
        end
        @(negedge clk);

        // reset then read
        apply(1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("rst_ready", {63'd0, iss_ready}, 64'd0);
        tick();
        apply(1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        tick();
        chk("rst_cnt", {58'd0, busy_cnt}, 64'd0);
        apply(0, 2'b11, 3, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("rst_rd", r_data[63:0] | r_data[127:64], 64'd0);
        chk("rst_ready1", {63'd0, iss_ready}, 64'd1);
        tick();

        // write-first bypass and stored value
        apply(0, 2'b01, 3, 0, 0, 0, 0, 2'b01, 3, 64'hDEAD_BEEF, 0, 0);
        chk("byp_3", r_data[63:0], 64'hDEAD_BEEF);
        tick();
        apply(0, 2'b01, 3, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("stored_3", r_data[63:0], 64'hDEAD_BEEF);
        tick();
        apply(0, 2'b01, 0, 0, 0, 0, 0, 2'b01, 0, 64'd5, 0, 0);
        chk("x0_byp", r_data[63:0], 64'd0);
        tick();
        apply(0, 2'b01, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("x0_read", r_data[63:0], 64'd0);
        tick();

        // RAW stall
        apply(0, 2'b00, 0, 0, 1, 1, 7, 2'b00, 0, 0, 0, 0);
        tick();
        chk("raw_cnt1", {58'd0, busy_cnt}, 64'd1);
        apply(0, 2'b10, 0, 7, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("raw_busy", {62'd0, r_busy}, 64'd2);
        chk("raw_stall", {63'd0, iss_ready}, 64'd0);
        tick();
        apply(0, 2'b10, 0, 7, 0, 0, 0, 2'b10, 0, 0, 7, 64'd42);
        chk("raw_byp", r_data[127:64], 64'd42);
        chk("raw_go", {63'd0, iss_ready}, 64'd1);
        tick();
        chk("raw_cnt0", {58'd0, busy_cnt}, 64'd0);

        // WAW stall
        apply(0, 2'b00, 0, 0, 1, 1, 9, 2'b00, 0, 0, 0, 0);
        tick();
        apply(0, 2'b00, 0, 0, 1, 1, 9, 2'b00, 0, 0, 0, 0);
        chk("waw_stall", {63'd0, iss_ready}, 64'd0);
        tick();
        apply(0, 2'b00, 0, 0, 1, 1, 9, 2'b01, 9, 64'd77, 0, 0);
        chk("waw_go", {63'd0, iss_ready}, 64'd1);
        tick();
        chk("waw_cnt", {58'd0, busy_cnt}, 64'd1);
        apply(0, 2'b01, 9, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("waw_busy9", {62'd0, r_busy}, 64'd1);
        tick();
        apply(0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 9, 64'd78, 0, 0);
        tick();

        // write-port conflict
        apply(0, 2'b01, 4, 0, 0, 0, 0, 2'b11, 4, 64'd1, 4, 64'd2);
        chk("conf_byp", r_data[63:0], 64'd2);
        tick();
        apply(0, 2'b01, 4, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("conf_st", r_data[63:0], 64'd2);
        tick();

        // reset mid-operation
        apply(0, 2'b00, 0, 0, 1, 1, 2, 2'b00, 0, 0, 0, 0);
        tick();
        apply(0, 2'b00, 0, 0, 1, 1, 5, 2'b00, 0, 0, 0, 0);
        tick();
        apply(0, 2'b00, 0, 0, 1, 1, 6, 2'b00, 0, 0, 0, 0);
        tick();
        chk("mid_cnt3", {58'd0, busy_cnt}, 64'd3);
        apply(1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        tick();
        chk("mid_cnt0", {58'd0, busy_cnt}, 64'd0);
        apply(0, 2'b11, 3, 4, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("mid_rd", r_data[63:0] | r_data[127:64], 64'd0);
        chk("mid_ready", {63'd0, iss_ready}, 64'd1);
        tick();

        // randomized traffic over a small address window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            apply($urandom_range(0, 99) == 0,
                  2'($urandom), 5'($urandom_range(0, 9)),
                  5'($urandom_range(0, 9)),
                  1'($urandom), 1'($urandom), 5'($urandom_range(0, 9)),
                  2'($urandom), 5'($urandom_range(0, 9)),
                  {$urandom, $urandom}, 5'($urandom_range(0, 9)),
                  {$urandom, $urandom});
            tick();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
